dsp_window3: RTL and testbench

DSP_WINDOW3 -- requirements
Module: dsp_window3

---
 rtl/dsp_window3_pkg.sv | 16 +
 rtl/dsp_window3_linebuf.sv | 20 ++
 rtl/dsp_window3.sv | 196 +++++++++++++++++++
 tb/tb_dsp_window3.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_window3_pkg.sv
// Shared types for the 3x3 window generator: pixel/window types, line limit and FSM states.
package dsp_window3_pkg;
  localparam int PIX_W_DEF = 8;
  localparam int MAX_WIDTH = 640;

  typedef logic [PIX_W_DEF-1:0] pixel_t;
  typedef pixel_t [2:0][2:0] window_t;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH,
    DONE
  } state_t;
endpackage

// File: rtl/dsp_window3_linebuf.sv
// One raster line of pixel storage: single port, combinational read of the old word, write on the edge.
module dsp_linebuf #(
  parameter int PIX_W     = 8,
  parameter int MAX_WIDTH = 640,
  parameter int AW        = $clog2(MAX_WIDTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [PIX_W-1:0] wdata_i,
  output logic [PIX_W-1:0] rdata_o
);
  logic [PIX_W-1:0] mem_q [MAX_WIDTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end
endmodule

// File: rtl/dsp_window3.sv
// 3x3 sliding-window generator over a raster stream using two chained line buffers.
// Border policy: DSP_WINDOW_REPLICATE_EN defined clamps to the edge pixel, otherwise out-of-image taps are 0.
module dsp_window3 #(
  parameter int PIX_W     = 8,
  parameter int MAX_WIDTH = dsp_window3_pkg::MAX_WIDTH
) (
  input  logic                    dsp_clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [10:0]             width,
  input  logic [10:0]             height,
  input  logic [PIX_W-1:0]        din,
  input  logic                    dinrdy,
  output logic [9*PIX_W-1:0]      win,
  output logic                    winrdy,
  output logic [10:0]             row,
  output logic [10:0]             col,
  output logic                    frame_done,
  output logic                    err,
  output dsp_window3_pkg::state_t dbg_state
);
  import dsp_window3_pkg::*;

  localparam int AW = $clog2(MAX_WIDTH);
  typedef logic [PIX_W-1:0] pix_t;

  // Handshake: dinrdy qualifies din for one cycle with no backpressure; winrdy marks win/row/col valid for one cycle.
  state_t            state_q;
  logic [10:0]       w_q, h_q, in_row_q, in_col_q, out_row_q, out_col_q, row_q, col_q;
  pix_t [2:0]        col_a_q, col_b_q, col_n;
  pix_t [8:0]        win_q, win_d;
  pix_t [2:0][2:0]   raw, rows_fix, fixed;
  pix_t              lb1_rd, lb2_rd;
  logic              winrdy_q, frame_done_q, err_q;
  logic              size_ok, accept, emit, shift, last_pix;
  logic              top_out, bot_out, left_out, right_out;
  logic [AW-1:0]     lb_addr;

  dsp_linebuf #(.PIX_W(PIX_W), .MAX_WIDTH(MAX_WIDTH), .AW(AW)) u_lb1 (
    .clk_i(dsp_clk), .we_i(accept), .addr_i(lb_addr), .wdata_i(din), .rdata_o(lb1_rd)
  );
  dsp_linebuf #(.PIX_W(PIX_W), .MAX_WIDTH(MAX_WIDTH), .AW(AW)) u_lb2 (
    .clk_i(dsp_clk), .we_i(accept), .addr_i(lb_addr), .wdata_i(lb1_rd), .rdata_o(lb2_rd)
  );

  always_comb begin
    size_ok  = (width >= 11'd3) && (int'(width) <= MAX_WIDTH) && (height >= 11'd2);
    last_pix = (in_row_q == h_q - 11'd1) && (in_col_q == w_q - 11'd1);
    case (state_q)
      IDLE:     accept = enable && dinrdy && size_ok;
      FILL,
      RUN:      accept = enable && dinrdy;
      default:  accept = 1'b0;
    endcase
    emit  = (state_q == RUN && accept) || (state_q == FLUSH && enable) ||
            (state_q == FILL && accept && in_row_q == 11'd1 && in_col_q == 11'd1);
    shift = accept || (state_q == FLUSH && enable);
    lb_addr = (state_q == IDLE) ? '0 : in_col_q[AW-1:0];
  end

  // Columns c-2, c-1 and the incoming column c form the window centred on (row-1, c-1).
  always_comb begin
    col_n[0]  = lb2_rd;
    col_n[1]  = lb1_rd;
    col_n[2]  = din;
    top_out   = (out_row_q == 11'd0);
    bot_out   = (out_row_q == h_q - 11'd1);
    left_out  = (out_col_q == 11'd0);
    right_out = (out_col_q == w_q - 11'd1);
    for (int r = 0; r < 3; r++) begin
      raw[r][0] = col_a_q[r];
      raw[r][1] = col_b_q[r];
      raw[r][2] = col_n[r];
    end
    rows_fix = raw;
`ifdef DSP_WINDOW_REPLICATE_EN
    if (top_out) rows_fix[0] = raw[1];
    if (bot_out) rows_fix[2] = raw[1];
    fixed = rows_fix;
    for (int r = 0; r < 3; r++) begin
      if (left_out)  fixed[r][0] = rows_fix[r][1];
      if (right_out) fixed[r][2] = rows_fix[r][1];
    end
`else
    if (top_out) rows_fix[0] = '0;
    if (bot_out) rows_fix[2] = '0;
    fixed = rows_fix;
    for (int r = 0; r < 3; r++) begin
      if (left_out)  fixed[r][0] = '0;
      if (right_out) fixed[r][2] = '0;
    end
`endif
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_d[3*r+c] = fixed[r][c];
      end
    end
  end

  always_ff @(posedge dsp_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      w_q          <= '0;
      h_q          <= '0;
      in_row_q     <= '0;
      in_col_q     <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      col_a_q      <= '0;
      col_b_q      <= '0;
      win_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      winrdy_q     <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      winrdy_q     <= 1'b0;
      frame_done_q <= 1'b0;
      if (emit) begin
        win_q    <= win_d;
        row_q    <= out_row_q;
        col_q    <= out_col_q;
        winrdy_q <= 1'b1;
        if (out_col_q == w_q - 11'd1) begin
          out_col_q <= '0;
          out_row_q <= out_row_q + 11'd1;
        end else begin
          out_col_q <= out_col_q + 11'd1;
        end
      end
      if (shift) begin
        col_a_q <= col_b_q;
        col_b_q <= col_n;
      end
      case (state_q)
        IDLE: begin
          if (enable && dinrdy) begin
            if (size_ok) begin
              w_q       <= width;
              h_q       <= height;
              err_q     <= 1'b0;
              in_row_q  <= '0;
              in_col_q  <= 11'd1;
              out_row_q <= '0;
              out_col_q <= '0;
              state_q   <= FILL;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        FILL, RUN: begin
          if (!enable) begin
            state_q <= IDLE;
          end else if (dinrdy) begin
            if (in_col_q == w_q - 11'd1) begin
              in_col_q <= '0;
              in_row_q <= in_row_q + 11'd1;
            end else begin
              in_col_q <= in_col_q + 11'd1;
            end
            if (state_q == FILL && in_row_q == 11'd1 && in_col_q == 11'd1) state_q <= RUN;
            if (state_q == RUN && last_pix) state_q <= FLUSH;
          end
        end
        FLUSH: begin
          // Virtual column W only supplies a masked right column for the last window.
          if (!enable) begin
            state_q <= IDLE;
          end else begin
            if (dinrdy) err_q <= 1'b1;
            if (in_col_q == w_q) state_q <= DONE;
            else in_col_q <= in_col_q + 11'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          if (enable) begin
            frame_done_q <= 1'b1;
            if (dinrdy) err_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign win        = win_q;
  assign winrdy     = winrdy_q;
  assign row        = row_q;
  assign col        = col_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_dsp_window3.sv
// Randomized scoreboard bench for dsp_window3 against an image-level reference window model.
module tb_dsp_window3;
  import dsp_window3_pkg::*;

  localparam int EXP_W = 72 + 11 + 11 + 32;

  logic        clk = 1'b0;
  logic        rst_n, enable, dinrdy;
  logic [10:0] width, height;
  logic [7:0]  din;
  logic [71:0] win;
  logic        winrdy, frame_done, err;
  logic [10:0] row, col;
  state_t      dbg_state;

  always #5 clk = ~clk;

  dsp_window3 #(.PIX_W(8), .MAX_WIDTH(640)) dut (
    .dsp_clk(clk), .reset_n(rst_n), .enable(enable), .width(width), .height(height),
    .din(din), .dinrdy(dinrdy), .win(win), .winrdy(winrdy), .row(row), .col(col),
    .frame_done(frame_done), .err(err), .dbg_state(dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0, n_win = 0;
  logic [EXP_W-1:0] exp_q[$];
  int               fd_q[$];
  logic [7:0]       img [0:15][0:15];
  int               fw, fh;
  logic [71:0]      seen00, seen11;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [71:0] pack9(int a0, int a1, int a2, int a3, int a4,
                                        int a5, int a6, int a7, int a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  // Reference: gather the 3x3 neighbourhood of (cr,cc) straight from the stored image.
  function automatic logic [71:0] model_win(int cr, int cc);
    logic [71:0] w = '0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        int r = cr + dr - 1;
        int c = cc + dc - 1;
`ifdef DSP_WINDOW_REPLICATE_EN
        if (r < 0) r = 0;
        if (r > fh - 1) r = fh - 1;
        if (c < 0) c = 0;
        if (c > fw - 1) c = fw - 1;
        w[(3*dr+dc)*8 +: 8] = img[r][c];
`else
        if (r >= 0 && r < fh && c >= 0 && c < fw) w[(3*dr+dc)*8 +: 8] = img[r][c];
`endif
      end
    end
    return w;
  endfunction

  task automatic push_win(input int m, input int stamp);
    int cr = m / fw;
    int cc = m % fw;
    exp_q.push_back({32'(stamp), 11'(cr), 11'(cc), model_win(cr, cc)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (winrdy) begin
        logic [EXP_W-1:0] e;
        n_win++;
        if (row == 11'd0 && col == 11'd0) seen00 = win;
        if (row == 11'd1 && col == 11'd1) seen11 = win;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_window: got row=%0d col=%0d win=%0h required none (cycle %0d)",
                   row, col, win, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("win_data", win, e[71:0]);
          chk("win_row_col", {row, col}, {e[93:83], e[82:72]});
          chk("win_cycle", cyc, e[125:94]);
        end
      end
      if (frame_done) begin
        if (fd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame_done: got 1 required 0 (cycle %0d)", cyc);
        end else begin
          chk("frame_done_cycle", cyc, fd_q.pop_front());
        end
      end
    end
  end

  task automatic send_frame(input int w, input int h, input bit seq, input int gap_min,
                            input int gap_max, input bit flush_din, input int limit);
    int npix = (limit > 0) ? limit : w * h;
    fw = w;
    fh = h;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        img[r][c] = seq ? 8'(r * w + c + 1) : 8'($urandom_range(0, 255));
    for (int k = 0; k < npix; k++) begin
      step();
      if (k == 0) begin
        width  = 11'(w);
        height = 11'(h);
      end else begin
        width  = 11'($urandom_range(0, 2047));
        height = 11'($urandom_range(0, 2047));
      end
      din    = img[k / w][k % w];
      dinrdy = 1'b1;
      if (k >= w + 1) push_win(k - w - 1, cyc + 1);
      if (gap_max > 0 && k < npix - 1) begin
        int g = $urandom_range(gap_min, gap_max);
        repeat (g) begin
          step();
          dinrdy = 1'b0;
          din    = 8'($urandom);
        end
      end
    end
    step();
    dinrdy = 1'b0;
    if (limit > 0) return;
    dinrdy = flush_din;
    din    = 8'($urandom);
    for (int i = 0; i <= w; i++) push_win(w * h - w - 1 + i, cyc + 1 + i);
    fd_q.push_back(cyc + w + 2);
    step();
    dinrdy = 1'b0;
    repeat (w + 4) step();
    chk("windows_drained", exp_q.size(), 0);
    chk("frame_done_drained", fd_q.size(), 0);
    chk("state_idle_after_frame", dbg_state, IDLE);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_win"}, win, 0);
    chk({tag, "_winrdy"}, winrdy, 0);
    chk({tag, "_row_col"}, {row, col}, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_state"}, dbg_state, IDLE);
  endtask

  logic [71:0] exp00;
  int          base;

  initial begin
`ifdef DSP_WINDOW_REPLICATE_EN
    exp00 = pack9(1, 1, 2, 1, 1, 2, 5, 5, 6);
`else
    exp00 = pack9(0, 0, 0, 0, 1, 2, 0, 5, 6);
`endif
    rst_n = 1'b0; enable = 1'b1; dinrdy = 1'b0; width = 11'd4; height = 11'd3; din = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // Directed 4x3 frame with pixels 1..12.
    seen00 = '0; seen11 = '0; base = n_win;
    send_frame(4, 3, 1'b1, 0, 0, 1'b0, 0);
    chk("directed_count", n_win - base, 12);
    chk("directed_first_win", seen00, exp00);
    chk("directed_centre11_win", seen11, pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));
    chk("directed_err", err, 0);

    // Same frame with an idle cycle between every pixel.
    base = n_win;
    send_frame(4, 3, 1'b1, 1, 1, 1'b0, 0);
    chk("gapped_count", n_win - base, 12);

    // Illegal sizes: too narrow, too wide, too short.
    for (int t = 0; t < 3; t++) begin
      step();
      width  = (t == 0) ? 11'd2 : (t == 1) ? 11'd700 : 11'd4;
      height = (t == 2) ? 11'd1 : 11'd3;
      dinrdy = 1'b1;
      din    = 8'($urandom);
      step();
      step();
      dinrdy = 1'b0;
      step();
      chk("illegal_err", err, 1);
      chk("illegal_state", dbg_state, IDLE);
    end

    // A legal frame clears the sticky error.
    base = n_win;
    send_frame(6, 4, 1'b0, 0, 0, 1'b0, 0);
    chk("err_cleared", err, 0);
    chk("frame6x4_count", n_win - base, 24);

    // Pixel offered during flush is dropped and flagged.
    base = n_win;
    send_frame(5, 3, 1'b0, 0, 0, 1'b1, 0);
    chk("flush_din_err", err, 1);
    chk("flush_din_count", n_win - base, 15);

    // Abort with enable low after nine pixels.
    base = n_win;
    send_frame(5, 3, 1'b0, 0, 0, 1'b0, 9);
    enable = 1'b0;
    step();
    chk("abort_state", dbg_state, IDLE);
    enable = 1'b1;
    repeat (6) step();
    chk("abort_count", n_win - base, 3);
    chk("abort_drained", exp_q.size(), 0);

    // Reset after the 7th pixel, then a clean frame.
    send_frame(4, 3, 1'b1, 0, 0, 1'b0, 7);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    chk("midreset_drained", exp_q.size(), 0);
    exp_q.delete();
    fd_q.delete();
    step();
    rst_n = 1'b1;
    seen00 = '0; base = n_win;
    send_frame(4, 3, 1'b1, 0, 0, 1'b0, 0);
    chk("post_reset_count", n_win - base, 12);
    chk("post_reset_first_win", seen00, exp00);

    // Random sizes, gaps and flush-time pixels.
    for (int f = 0; f < 6; f++) begin
      int w = $urandom_range(3, 9);
      int h = $urandom_range(2, 6);
      bit fd = 1'($urandom_range(0, 1));
      base = n_win;
      send_frame(w, h, 1'b0, 0, $urandom_range(0, 2), fd, 0);
      chk("random_count", n_win - base, w * h);
      chk("random_err", err, 128'(fd));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
